// File: rtl/pll_clk_en_pkg.sv
// rtl/pll_clk_en_pkg.sv - shared types and effective-config helper for the clock-enable generator
package pll_clk_en_pkg;

    // Default width of ratio/duty/phase fields and channel counters
    localparam int CNT_W_DEF = 10;

    // Config fields are stored at this width so that any CNT_W up to 16 fits one struct type
    localparam int CFG_W_MAX = 16;

    localparam logic [CFG_W_MAX-1:0] CFG_ONE = {{(CFG_W_MAX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        ALIGN     = 2'd1,
        RUN       = 2'd2
    } state_e;

    typedef struct packed {
        logic [CFG_W_MAX-1:0] ratio;
        logic [CFG_W_MAX-1:0] duty;
        logic [CFG_W_MAX-1:0] phase;
    } ch_cfg_t;

    // Clamp a programmed config: R = max(ratio,1), P = min(phase,R-1), D = min(duty,R)
    function automatic ch_cfg_t eff_cfg(input ch_cfg_t c);
        ch_cfg_t e;
        e.ratio = (c.ratio == '0) ? CFG_ONE : c.ratio;
        e.phase = (c.phase > (e.ratio - CFG_ONE)) ? (e.ratio - CFG_ONE) : c.phase;
        e.duty  = (c.duty > e.ratio) ? e.ratio : c.duty;
        return e;
    endfunction

endpackage

// File: rtl/pll_clk_en_ch.sv
// rtl/pll_clk_en_ch.sv - one enable/level channel with counter, active config and apply-at-wrap shadow
module pll_clk_en_ch
    import pll_clk_en_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int DEF_RATIO = 6,
    parameter int DEF_DUTY  = 3,
    parameter int DEF_PHASE = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  logic    step_i,
    input  logic    drop_i,
    input  logic    wr_i,
    input  ch_cfg_t wr_cfg_i,
    output logic    en_o,
    output logic    lvl_o,
    output logic    pend_nxt_o
);

    localparam ch_cfg_t DEF_CFG = '{
        ratio: CFG_W_MAX'(DEF_RATIO),
        duty:  CFG_W_MAX'(DEF_DUTY),
        phase: CFG_W_MAX'(DEF_PHASE)
    };
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             lvl_q, lvl_d;
    ch_cfg_t          eff_cur;
    ch_cfg_t          eff_nxt;
    logic             wrap;

    // Counter advance, shadow application at wrap, and next registered outputs
    always_comb begin
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        lvl_d   = 1'b0;
        wrap    = 1'b0;
        eff_cur = eff_cfg(act_q);
        if (step_i) begin
            wrap = (CFG_W_MAX'(cnt_q) >= (eff_cur.ratio - CFG_ONE));
            if (wrap) begin
                cnt_d = '0;
                // New period begins at cnt=0 with the new config, so no runt pulse
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (load_i) begin
            cnt_d = '0;
        end
        eff_nxt = eff_cfg(act_d);
        if (step_i || load_i) begin
            en_d  = (CFG_W_MAX'(cnt_d) == eff_nxt.phase);
            lvl_d = (CFG_W_MAX'(cnt_d) < eff_nxt.duty);
        end
        if (drop_i) begin
            pend_d = 1'b0;
        end
        if (wr_i) begin
            shd_d  = wr_cfg_i;
            pend_d = 1'b1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= DEF_CFG;
            shd_q  <= DEF_CFG;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            lvl_q  <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            lvl_q  <= lvl_d;
        end
    end

    assign en_o       = en_q;
    assign lvl_o      = lvl_q;
    assign pend_nxt_o = pend_d;

endmodule

// File: rtl/pll_clk_en_gen.sv
// rtl/pll_clk_en_gen.sv - lock filter, alignment FSM and config handshake driving NUM_CH enable channels
module pll_clk_en_gen
    import pll_clk_en_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LOCK_HOLD = 16,
    parameter int DEF_RATIO = 6,
    parameter int DEF_DUTY  = 3,
    parameter int DEF_PHASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_ratio,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              clr_lost,
    output logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] ch_lvl,
    output logic              lock_ok,
    output logic              lock_lost,
    output logic              rst_out
);

    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    logic              lock_meta_q, lock_s_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    state_e            state_q, state_d;
    logic              lock_ok_q, rst_out_q;
    logic              lock_lost_q, lock_lost_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              accept, ch_ok;
    logic              load, step, drop;
    logic [NUM_CH-1:0] pend_nxt;
    ch_cfg_t           wr_cfg;

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Hold counter, state transitions and handshake next-state
    always_comb begin
        hold_d = '0;
        if (lock_s_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
        end

        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (hold_d == HOLD_MAX) state_d = ALIGN;
            ALIGN:     state_d = lock_s_q ? RUN : WAIT_LOCK;
            RUN:       if (!lock_s_q) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase

        load = (state_q == ALIGN) && (state_d == RUN);
        step = (state_q == RUN) && (state_d == RUN);
        drop = (state_q == RUN) && (state_d != RUN);

        accept = cfg_valid && cfg_ready_q;
        ch_ok  = (32'(cfg_ch) < 32'(NUM_CH));

        // Set wins over clear when lock drops in the same cycle clr_lost is asserted
        lock_lost_d = lock_lost_q;
        if (clr_lost) lock_lost_d = 1'b0;
        if (drop)     lock_lost_d = 1'b1;

        // Out-of-range channel writes still cost one low cycle of ready
        cfg_ready_d = (state_d == RUN) && !accept && !(|pend_nxt);
    end

    // FSM state, hold counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_LOCK;
            hold_q      <= '0;
            lock_ok_q   <= 1'b0;
            rst_out_q   <= 1'b1;
            lock_lost_q <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            lock_ok_q   <= (state_d != WAIT_LOCK);
            rst_out_q   <= (state_d != RUN);
            lock_lost_q <= lock_lost_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign wr_cfg = '{
        ratio: CFG_W_MAX'(cfg_ratio),
        duty:  CFG_W_MAX'(cfg_duty),
        phase: CFG_W_MAX'(cfg_phase)
    };

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_clk_en_ch #(
            .CNT_W     (CNT_W),
            .DEF_RATIO (DEF_RATIO),
            .DEF_DUTY  (DEF_DUTY),
            .DEF_PHASE (DEF_PHASE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load),
            .step_i     (step),
            .drop_i     (drop),
            .wr_i       (accept && ch_ok && step && (cfg_ch == 3'(i))),
            .wr_cfg_i   (wr_cfg),
            .en_o       (ch_en[i]),
            .lvl_o      (ch_lvl[i]),
            .pend_nxt_o (pend_nxt[i])
        );
    end

    assign cfg_ready = cfg_ready_q;
    assign lock_ok   = lock_ok_q;
    assign lock_lost = lock_lost_q;
    assign rst_out   = rst_out_q;

endmodule

// File: tb/tb_pll_clk_en_gen.sv
// tb/tb_pll_clk_en_gen.sv - scoreboard bench for pll_clk_en_gen
module tb_pll_clk_en_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pll_lock = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_ratio = '0;
    logic [CNT_W-1:0]  cfg_duty = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic              clr_lost = 1'b0;
    logic [NUM_CH-1:0] ch_en, ch_lvl;
    logic              lock_ok, lock_lost, rst_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int b, b2;
    int exp_q [NUM_CH][$];

    pll_clk_en_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_HOLD(16),
        .DEF_RATIO(6), .DEF_DUTY(3), .DEF_PHASE(0)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_ratio(cfg_ratio), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase),
        .clr_lost(clr_lost), .ch_en(ch_en), .ch_lvl(ch_lvl),
        .lock_ok(lock_ok), .lock_lost(lock_lost), .rst_out(rst_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_per(input int ch, input int start, input int per, input int n);
        for (int k = 0; k < n; k++) exp_q[ch].push_back(start + k * per);
    endtask

    task automatic cfg_write(input int ch, input int r, input int d, input int p);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_ratio = CNT_W'(r);
        cfg_duty  = CNT_W'(d);
        cfg_phase = CNT_W'(p);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ch_en"},     32'(ch_en),  0);
        chk({tag, "_ch_lvl"},    32'(ch_lvl), 0);
        chk({tag, "_lock_ok"},   32'(lock_ok), 0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 0);
        chk({tag, "_rst_out"},   32'(rst_out), 1);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    endtask

    // Monitor: every ch_en pulse must match the head of that channel's expected-cycle queue
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL ch_en%0d missed: no pulse at cycle %0d, required 1", c, exp_q[c][0]);
                void'(exp_q[c].pop_front());
            end
            if (ch_en[c]) begin
                checks++;
                if (exp_q[c].size() > 0 && exp_q[c][0] == cyc) begin
                    void'(exp_q[c].pop_front());
                end else begin
                    failures++;
                    $display("FAIL ch_en%0d unexpected: got 1 at cycle %0d, required 0", c, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        at(1);
        chk_reset_vals("reset1");
        at(2);
        rst = 1'b0;
        b = 2;
        // Segment 1 expected enable pulses (cycle offsets from b)
        push_per(0, b + 19, 6, 5);
        push_per(0, b + 67, 6, 1);
        push_per(0, b + 73, 1, 13);
        push_per(1, b + 19, 6, 2);
        push_per(1, b + 33, 4, 4);
        push_per(1, b + 69, 4, 5);
        push_per(2, b + 19, 6, 5);
        push_per(2, b + 67, 6, 2);
        push_per(2, b + 82, 4, 1);

        // Lock filter and alignment
        at(b + 17); chk("lock_ok_pre", 32'(lock_ok), 0);
        at(b + 18); chk("lock_ok_align", 32'(lock_ok), 1);
                    chk("rst_out_align", 32'(rst_out), 1);
        at(b + 19); chk("rst_out_run", 32'(rst_out), 0);
                    chk("cfg_ready_run", 32'(cfg_ready), 1);
        for (int k = 0; k < 6; k++) begin
            at(b + 19 + k);
            chk("lvl0_default", 32'(ch_lvl[0]), (k < 3) ? 1 : 0);
        end

        // Mid-period reconfig of ch1
        at(b + 27); chk("cfg_ready_before_wr", 32'(cfg_ready), 1);
                    cfg_write(1, 4, 1, 2);
        at(b + 28); cfg_valid = 1'b0;
                    chk("cfg_ready_pending", 32'(cfg_ready), 0);
        at(b + 30); chk("cfg_ready_pending2", 32'(cfg_ready), 0);
        at(b + 31); chk("cfg_ready_applied", 32'(cfg_ready), 1);
                    chk("lvl1_new_c0", 32'(ch_lvl[1]), 1);
        at(b + 32); chk("lvl1_new_c1", 32'(ch_lvl[1]), 0);

        // Lock loss and relock
        at(b + 45); pll_lock = 1'b0;
        at(b + 47); chk("lock_ok_before_loss", 32'(lock_ok), 1);
        at(b + 48); chk("loss_ch_en", 32'(ch_en), 0);
                    chk("loss_ch_lvl", 32'(ch_lvl), 0);
                    chk("loss_lock_ok", 32'(lock_ok), 0);
                    chk("loss_rst_out", 32'(rst_out), 1);
                    chk("loss_lock_lost", 32'(lock_lost), 1);
                    chk("loss_cfg_ready", 32'(cfg_ready), 0);
                    pll_lock = 1'b1;
        at(b + 65); chk("relock_pre", 32'(lock_ok), 0);
        at(b + 66); chk("relock_align", 32'(lock_ok), 1);
        at(b + 67); chk("relock_rst_out", 32'(rst_out), 0);
        at(b + 68); chk("lock_lost_sticky", 32'(lock_lost), 1);
                    clr_lost = 1'b1;
        at(b + 69); clr_lost = 1'b0;
                    chk("lock_lost_cleared", 32'(lock_lost), 0);

        // Edge configs: ratio=0 on ch0, duty/phase clamp on ch2
        at(b + 70); cfg_write(0, 0, 5, 3);
        at(b + 71); cfg_valid = 1'b0;
                    chk("cfg_ready_ch0_pend", 32'(cfg_ready), 0);
        at(b + 73); chk("cfg_ready_ch0_done", 32'(cfg_ready), 1);
                    chk("lvl0_r1", 32'(ch_lvl[0]), 1);
                    cfg_write(2, 4, 10, 9);
        at(b + 74); cfg_valid = 1'b0;
                    chk("cfg_ready_ch2_pend", 32'(cfg_ready), 0);
        at(b + 78); chk("lvl2_old_low", 32'(ch_lvl[2]), 0);
        at(b + 79); chk("cfg_ready_ch2_done", 32'(cfg_ready), 1);
                    chk("lvl2_clamped_a", 32'(ch_lvl[2]), 1);

        // Out-of-range channel write
        at(b + 80); chk("lvl2_clamped_b", 32'(ch_lvl[2]), 1);
                    cfg_write(5, 2, 1, 0);
        at(b + 81); cfg_valid = 1'b0;
                    chk("cfg_ready_bad_ch", 32'(cfg_ready), 0);
                    chk("lvl0_r1_b", 32'(ch_lvl[0]), 1);
        at(b + 82); chk("cfg_ready_bad_ch_back", 32'(cfg_ready), 1);
                    chk("lvl2_clamped_c", 32'(ch_lvl[2]), 1);

        // Reset with a pending config on ch1
        at(b + 83); cfg_write(1, 3, 2, 1);
        at(b + 84); cfg_valid = 1'b0;
                    chk("cfg_ready_ch1_pend", 32'(cfg_ready), 0);
        at(b + 85); chk("cfg_ready_ch1_pend2", 32'(cfg_ready), 0);
                    rst = 1'b1;
        at(b + 86); chk_reset_vals("reset2");
        at(b + 87); rst = 1'b0;
        b2 = b + 87;
        for (int c = 0; c < NUM_CH; c++) push_per(c, b2 + 19, 6, 3);

        at(b2 + 18); chk("lock_ok_after_rst", 32'(lock_ok), 1);
        for (int k = 0; k < 6; k++) begin
            at(b2 + 19 + k);
            chk("lvl_defaults_restored", 32'(ch_lvl), (k < 3) ? 32'h7 : 32'h0);
        end

        at(b2 + 34);
        for (int c = 0; c < NUM_CH; c++) chk("sb_drain", 32'(exp_q[c].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
